// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 unified-memory arbiter: priority state,
// requester IDs, default bus widths and the winner-selection rule.
package mips32_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   typedef enum logic {
      DATA_PRI  = 1'b0,
      FETCH_PRI = 1'b1
   } pri_state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_t;

   // Only a tie is resolved by the priority state; a lone eligible requester always wins.
   function automatic req_id_t pick_winner(input pri_state_t st,
                                           input logic fetch_ok,
                                           input logic data_ok);
      if (fetch_ok && data_ok) return (st == FETCH_PRI) ? REQ_IF : REQ_D;
      else if (fetch_ok)       return REQ_IF;
      else                     return REQ_D;
   endfunction

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Pipeline-side request/response bus plus memory-macro bus of the arbiter.
// slave is the arbiter's view; master is the pipeline/memory environment.
interface mips32_mem_arbiter_if
   import mips32_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              halt;
   logic              busy;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, busy,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, busy,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mips32_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; 'last' flags the
// count at which one more denial means fetch must be promoted.
module mips32_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic last
);
   logic [3:0] cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                cnt <= '0;
      else if (clr)                              cnt <= '0;
      else if (inc && (cnt != 4'(STARVE_MAX)))   cnt <= cnt + 4'd1;
   end

   assign last = (cnt == 4'(STARVE_MAX - 1));
endmodule

// File: rtl/mips32_mem_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the
// MEM stage: data-first priority with a starvation guard, flush and halt.
module mips32_mem_arbiter
   import mips32_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_MAX = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   mips32_mem_arbiter_if.slave bus
);
   pri_state_t        pri_state, pri_next;
   req_id_t           winner;
   logic              fetch_ok, data_ok;
   logic              starve_last;
   logic              if_pend, d_pend;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   // Grants are gated by rst_n so nothing reaches the macro while reset is held.
   always_comb begin
      fetch_ok   = rst_n & ~bus.halt & bus.if_req & ~bus.if_flush;
      data_ok    = rst_n & ~bus.halt & bus.d_req;
      winner     = pick_winner(pri_state, fetch_ok, data_ok);
      bus.if_gnt = fetch_ok & (winner == REQ_IF);
      bus.d_gnt  = data_ok & (winner == REQ_D);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pri_state <= DATA_PRI;
      else        pri_state <= pri_next;
   end

   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would infer a latch.
   always_comb begin
      pri_next = pri_state;
      case (pri_state)
         DATA_PRI:  if (bus.if_req && !bus.if_gnt && starve_last) pri_next = FETCH_PRI;
         FETCH_PRI: if (bus.if_gnt)                               pri_next = DATA_PRI;
      endcase
   end

   mips32_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bus.if_req & ~bus.if_gnt & ~bus.if_flush & ~bus.halt),
      .clr   (bus.if_gnt | ~bus.if_req),
      .last  (starve_last)
   );

   // Idle cycles keep the last address/data on the macro pins.
   always_comb begin
      bus.mem_en    = bus.if_gnt | bus.d_gnt;
      bus.mem_we    = bus.d_gnt & bus.d_we;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      if (bus.d_gnt) begin
         bus.mem_addr  = bus.d_addr;
         bus.mem_wdata = bus.d_wdata;
      end else if (bus.if_gnt) begin
         bus.mem_addr  = bus.if_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         if_pend <= 1'b0;
         d_pend  <= 1'b0;
      end else begin
         addr_q  <= bus.mem_addr;
         wdata_q <= bus.mem_wdata;
         if_pend <= bus.if_gnt;
         d_pend  <= bus.d_gnt & ~bus.d_we;
      end
   end

   assign bus.if_rvalid = if_pend & ~bus.if_flush;
   assign bus.d_rvalid  = d_pend;
   assign bus.if_rdata  = bus.mem_rdata;
   assign bus.d_rdata   = bus.mem_rdata;
   assign bus.busy      = if_pend | d_pend;
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: vector table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_mips32_mem_arbiter;
   localparam int SM = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mips32_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

   mips32_mem_arbiter #(
      .ADDR_W     (10),
      .DATA_W     (32),
      .STARVE_MAX (SM)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory macro: 1-cycle synchronous read.
   logic [31:0] mem [1024];
   logic [31:0] mem_rdata_q = '0;
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            mem_rdata_q <= mem[bus.mem_addr];
      end
   end
   assign bus.mem_rdata = mem_rdata_q;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [31:0] ref_mem [1024];
   int          denied;       // consecutive denied fetch cycles
   bit          fetch_first;  // fetch currently promoted
   bit          p_if, p_d;
   logic [31:0] p_if_data, p_d_data;
   logic [9:0]  last_addr;
   logic [31:0] last_wdata;
   bit          m_ig, m_dg;

   task automatic model_reset();
      denied = 0; fetch_first = 0; p_if = 0; p_d = 0;
      last_addr = '0; last_wdata = '0; m_ig = 0; m_dg = 0;
   endtask

   task automatic model_eval();
      bit want_if, want_d;
      want_if = bus.if_req && !bus.if_flush && !bus.halt;
      want_d  = bus.d_req && !bus.halt;
      if (want_if && want_d) begin
         m_ig = fetch_first;
         m_dg = !fetch_first;
      end else begin
         m_ig = want_if;
         m_dg = want_d;
      end
   endtask

   task automatic model_commit();
      p_if      = m_ig;
      p_if_data = ref_mem[bus.if_addr];
      p_d       = m_dg && !bus.d_we;
      p_d_data  = ref_mem[bus.d_addr];
      if (m_dg) begin
         last_addr  = bus.d_addr;
         last_wdata = bus.d_wdata;
         if (bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
      end else if (m_ig) begin
         last_addr = bus.if_addr;
      end
      if (m_ig)                                                fetch_first = 0;
      else if (!fetch_first && bus.if_req && denied == SM - 1) fetch_first = 1;
      if (m_ig || !bus.if_req)                                  denied = 0;
      else if (!bus.if_flush && !bus.halt && denied < SM)       denied++;
   endtask

   // Inputs are driven at negedge; outputs are compared 2 units later.
   task automatic settle();
      bit exp_irv;
      #2;
      model_eval();
      exp_irv = p_if && !bus.if_flush;
      check("if_gnt",    bus.if_gnt,    m_ig);
      check("d_gnt",     bus.d_gnt,     m_dg);
      check("mem_en",    bus.mem_en,    m_ig | m_dg);
      check("mem_we",    bus.mem_we,    m_dg & bus.d_we);
      check("mem_addr",  bus.mem_addr,  m_dg ? bus.d_addr : (m_ig ? bus.if_addr : last_addr));
      check("mem_wdata", bus.mem_wdata, m_dg ? bus.d_wdata : last_wdata);
      check("if_rvalid", bus.if_rvalid, exp_irv);
      check("d_rvalid",  bus.d_rvalid,  p_d);
      check("busy",      bus.busy,      p_if | p_d);
      if (exp_irv) check("if_rdata", bus.if_rdata, p_if_data);
      if (p_d)     check("d_rdata",  bus.d_rdata,  p_d_data);
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.halt = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_if_gnt"},    bus.if_gnt,    1'b0);
      check({tag, "_d_gnt"},     bus.d_gnt,     1'b0);
      check({tag, "_if_rvalid"}, bus.if_rvalid, 1'b0);
      check({tag, "_d_rvalid"},  bus.d_rvalid,  1'b0);
      check({tag, "_busy"},      bus.busy,      1'b0);
      check({tag, "_mem_en"},    bus.mem_en,    1'b0);
      check({tag, "_mem_we"},    bus.mem_we,    1'b0);
      check({tag, "_mem_addr"},  bus.mem_addr,  10'd0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
   endtask

   typedef struct {
      logic        if_req, if_flush, d_req, d_we, halt;
      logic [9:0]  if_addr, d_addr;
      logic [31:0] d_wdata;
      logic        exp_if_gnt, exp_d_gnt, exp_mem_we;
   } vec_t;

   vec_t vecs [9];

   initial begin
      // inputs: if_req flush d_req d_we halt | if_addr d_addr wdata | expected gnts/we
      vecs[0] = '{0, 0, 0, 0, 0, 10'd0,  10'd0,  32'h0,        0, 0, 0};
      vecs[1] = '{1, 0, 0, 0, 0, 10'd1,  10'd0,  32'h0,        1, 0, 0};
      vecs[2] = '{0, 0, 1, 0, 0, 10'd0,  10'd2,  32'h0,        0, 1, 0};
      vecs[3] = '{0, 0, 1, 1, 0, 10'd0,  10'd40, 32'h12345678, 0, 1, 1};
      vecs[4] = '{1, 0, 1, 0, 0, 10'd3,  10'd40, 32'h0,        0, 1, 0};
      vecs[5] = '{1, 1, 0, 0, 0, 10'd3,  10'd0,  32'h0,        0, 0, 0};
      vecs[6] = '{1, 0, 1, 1, 1, 10'd3,  10'd41, 32'hCAFEF00D, 0, 0, 0};
      vecs[7] = '{0, 0, 1, 0, 1, 10'd0,  10'd41, 32'h0,        0, 0, 0};
      vecs[8] = '{1, 0, 0, 0, 0, 10'd3,  10'd0,  32'h0,        1, 0, 0};

      for (int i = 0; i < 1024; i++) begin
         mem[i]     = 32'hA500_0000 ^ (i * 32'h0001_0203);
         ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
      end
      idle_inputs();
      model_reset();

      // ---- reset state ----
      rst_n = 0;
      @(negedge clk);
      #2 check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1;

      // ---- vector table ----
      for (int i = 0; i < 9; i++) begin
         bus.if_req = vecs[i].if_req;  bus.if_flush = vecs[i].if_flush;
         bus.d_req  = vecs[i].d_req;   bus.d_we     = vecs[i].d_we;
         bus.halt   = vecs[i].halt;    bus.if_addr  = vecs[i].if_addr;
         bus.d_addr = vecs[i].d_addr;  bus.d_wdata  = vecs[i].d_wdata;
         settle();
         check($sformatf("vec%0d_if_gnt", i), bus.if_gnt, vecs[i].exp_if_gnt);
         check($sformatf("vec%0d_d_gnt", i),  bus.d_gnt,  vecs[i].exp_d_gnt);
         check($sformatf("vec%0d_mem_we", i), bus.mem_we, vecs[i].exp_mem_we);
         advance();
      end
      idle_inputs();
      settle(); advance();

      // ---- reset mid-access ----
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd5;
      settle();
      check("rma_d_gnt", bus.d_gnt, 1'b1);
      advance();
      rst_n = 0;
      #2 check_reset_outputs("rma");
      @(negedge clk);
      rst_n = 1;
      idle_inputs();
      model_reset();
      for (int i = 0; i < 2; i++) begin
         settle();
         check("rma_no_rvalid", bus.d_rvalid, 1'b0);
         advance();
      end

      // ---- contention / starvation guard ----
      for (int i = 0; i < 6; i++) begin
         bus.if_req = 1; bus.if_addr = (i < 5) ? 10'd100 : 10'd101;
         bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'(200 + i);
         settle();
         check($sformatf("starve%0d_if_gnt", i), bus.if_gnt, (i == 4));
         check($sformatf("starve%0d_d_gnt", i),  bus.d_gnt,  (i != 4));
         advance();
      end
      idle_inputs();
      settle(); advance();

      // ---- store then load ----
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 10'd12; bus.d_wdata = 32'hDEADBEEF;
      settle();
      check("st_d_gnt", bus.d_gnt, 1'b1);
      check("st_mem_we", bus.mem_we, 1'b1);
      advance();
      bus.d_we = 0; bus.d_wdata = '0;
      settle();
      check("st_no_rvalid", bus.d_rvalid, 1'b0);
      check("ld_d_gnt", bus.d_gnt, 1'b1);
      advance();
      idle_inputs();
      settle();
      check("ld_rvalid", bus.d_rvalid, 1'b1);
      check("ld_rdata", bus.d_rdata, 32'hDEADBEEF);
      advance();

      // ---- fetch flush ----
      bus.if_req = 1; bus.if_addr = 10'd7;
      settle();
      check("fl_gnt_n", bus.if_gnt, 1'b1);
      advance();
      bus.if_flush = 1; bus.if_addr = 10'd20;
      settle();
      check("fl_rvalid_n1", bus.if_rvalid, 1'b0);
      check("fl_gnt_n1", bus.if_gnt, 1'b0);
      advance();
      bus.if_flush = 0;
      settle();
      check("fl_gnt_n2", bus.if_gnt, 1'b1);
      advance();
      idle_inputs();
      settle();
      check("fl_rvalid_n3", bus.if_rvalid, 1'b1);
      check("fl_rdata_n3", bus.if_rdata, ref_mem[20]);
      advance();

      // ---- halt drain ----
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd3;
      settle(); advance();
      bus.halt = 1; bus.if_req = 1; bus.if_addr = 10'd30; bus.d_addr = 10'd31;
      settle();
      check("halt_d_rvalid", bus.d_rvalid, 1'b1);
      check("halt_d_rdata", bus.d_rdata, ref_mem[3]);
      check("halt_busy1", bus.busy, 1'b1);
      check("halt_gnt1", {bus.if_gnt, bus.d_gnt}, 2'b00);
      advance();
      settle();
      check("halt_busy0", bus.busy, 1'b0);
      check("halt_gnt2", {bus.if_gnt, bus.d_gnt}, 2'b00);
      advance();
      bus.halt = 0;
      settle(); advance();
      idle_inputs();
      settle(); advance();

      // ---- fetch only, 10 consecutive addresses ----
      for (int i = 0; i < 10; i++) begin
         bus.if_req = 1; bus.if_addr = 10'(i);
         settle();
         check($sformatf("fo%0d_gnt", i), bus.if_gnt, 1'b1);
         if (i > 0) check($sformatf("fo%0d_rdata", i), bus.if_rdata, ref_mem[i - 1]);
         check($sformatf("fo%0d_starve", i), dut.u_starve.cnt, 4'd0);
         advance();
      end
      idle_inputs();
      settle();
      check("fo_last_rvalid", bus.if_rvalid, 1'b1);
      advance();

      // ---- random traffic vs model ----
      for (int c = 0; c < 600; c++) begin
         if (!bus.if_req || m_ig) begin
            bus.if_req  = ($urandom_range(0, 2) != 0);
            bus.if_addr = 10'($urandom_range(0, 31));
         end
         if (!bus.d_req || m_dg) begin
            bus.d_req   = ($urandom_range(0, 2) != 0);
            bus.d_we    = ($urandom_range(0, 2) == 0);
            bus.d_addr  = 10'($urandom_range(0, 31));
            bus.d_wdata = $urandom;
         end
         bus.if_flush = ($urandom_range(0, 5) == 0);
         bus.halt     = ($urandom_range(0, 19) == 0);
         settle();
         advance();
      end
      idle_inputs();
      settle(); advance();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
